// File: rtl/rfid_access_gate.sv
// rtl/rfid_access_gate.sv - RFID card-check gate: timed firewall session, fail counting and lockout
// Consumes reader verdicts, opens fw_enable for a timed session, locks out after repeated denials.
module rfid_access_gate #(
  parameter logic [31:0] SESSION_CYCLES = 32'd50_000_000,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd100_000_000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_strobe,
  input  logic        card_valid,
  input  logic [31:0] card_uid,
  input  logic        force_lock,
  output logic        fw_enable,
  output logic        lockout,
  output logic        grant_pulse,
  output logic        deny_pulse,
  output logic [31:0] session_uid,
  output logic [3:0]  fail_count
);

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_GRANTED,
    ST_LOCKOUT
  } state_e;

  localparam logic [3:0] MaxFails = 4'(MAX_FAILS);

  state_e      state_q;
  logic [31:0] timer_q;
  logic        fw_enable_q;
  logic        lockout_q;
  logic        grant_pulse_q;
  logic        deny_pulse_q;
  logic [31:0] session_uid_q;
  logic [3:0]  fail_count_q;

  // A strobe only counts when the host is not overriding and no lockout is running.
  logic card_event;
  assign card_event = card_strobe & ~force_lock & (state_q != ST_LOCKOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOCKED;
      timer_q       <= 32'd0;
      fw_enable_q   <= 1'b0;
      lockout_q     <= 1'b0;
      grant_pulse_q <= 1'b0;
      deny_pulse_q  <= 1'b0;
      session_uid_q <= 32'd0;
      fail_count_q  <= 4'd0;
    end else begin
      grant_pulse_q <= 1'b0;
      deny_pulse_q  <= 1'b0;
      case (state_q)
        ST_LOCKED: begin
          if (card_event) begin
            if (card_valid) begin
              state_q       <= ST_GRANTED;
              fw_enable_q   <= 1'b1;
              grant_pulse_q <= 1'b1;
              session_uid_q <= card_uid;
              fail_count_q  <= 4'd0;
              timer_q       <= SESSION_CYCLES - 32'd1;
            end else begin
              deny_pulse_q <= 1'b1;
              if (fail_count_q + 4'd1 == MaxFails) begin
                state_q      <= ST_LOCKOUT;
                lockout_q    <= 1'b1;
                fail_count_q <= 4'd0;
                timer_q      <= LOCKOUT_CYCLES - 32'd1;
              end else begin
                fail_count_q <= fail_count_q + 4'd1;
              end
            end
          end
        end

        ST_GRANTED: begin
          if (force_lock) begin
            state_q     <= ST_LOCKED;
            fw_enable_q <= 1'b0;
            timer_q     <= 32'd0;
          end else if (card_event && card_valid) begin
            // Re-presenting a good card extends the session without a gap.
            timer_q       <= SESSION_CYCLES - 32'd1;
            session_uid_q <= card_uid;
            grant_pulse_q <= 1'b1;
          end else begin
            if (card_event) deny_pulse_q <= 1'b1;
            if (timer_q == 32'd0) begin
              state_q     <= ST_LOCKED;
              fw_enable_q <= 1'b0;
            end else begin
              timer_q <= timer_q - 32'd1;
            end
          end
        end

        ST_LOCKOUT: begin
          if (timer_q == 32'd0) begin
            state_q   <= ST_LOCKED;
            lockout_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end

        default: begin
          state_q     <= ST_LOCKED;
          fw_enable_q <= 1'b0;
          lockout_q   <= 1'b0;
          timer_q     <= 32'd0;
        end
      endcase
    end
  end

  assign fw_enable   = fw_enable_q;
  assign lockout     = lockout_q;
  assign grant_pulse = grant_pulse_q;
  assign deny_pulse  = deny_pulse_q;
  assign session_uid = session_uid_q;
  assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_rfid_access_gate.sv
// tb/tb_rfid_access_gate.sv - directed self-checking bench for rfid_access_gate
// Vector table plus hand sequences for session/lockout timing, override and reset.
module tb_rfid_access_gate;

  logic        clk;
  logic        rst_n;
  logic        card_strobe;
  logic        card_valid;
  logic [31:0] card_uid;
  logic        force_lock;
  logic        fw_enable;
  logic        lockout;
  logic        grant_pulse;
  logic        deny_pulse;
  logic [31:0] session_uid;
  logic [3:0]  fail_count;

  int n_checks = 0;
  int n_fails  = 0;

  rfid_access_gate #(
    .SESSION_CYCLES(32'd20),
    .LOCKOUT_CYCLES(32'd30),
    .MAX_FAILS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .card_strobe(card_strobe),
    .card_valid(card_valid),
    .card_uid(card_uid),
    .force_lock(force_lock),
    .fw_enable(fw_enable),
    .lockout(lockout),
    .grant_pulse(grant_pulse),
    .deny_pulse(deny_pulse),
    .session_uid(session_uid),
    .fail_count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idle;
    logic        strobe;
    logic        valid;
    logic [31:0] uid;
    logic        force_l;
    logic        fw;
    logic        lk;
    logic        gp;
    logic        dp;
    logic [31:0] suid;
    logic [3:0]  fail;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic fw, input logic lk, input logic gp,
                         input logic dp, input logic [31:0] suid, input logic [3:0] fail);
    chk({tag, " fw_enable"}, {31'd0, fw_enable}, {31'd0, fw});
    chk({tag, " lockout"}, {31'd0, lockout}, {31'd0, lk});
    chk({tag, " grant_pulse"}, {31'd0, grant_pulse}, {31'd0, gp});
    chk({tag, " deny_pulse"}, {31'd0, deny_pulse}, {31'd0, dp});
    chk({tag, " session_uid"}, session_uid, suid);
    chk({tag, " fail_count"}, {28'd0, fail_count}, {28'd0, fail});
  endtask

  task automatic strobe_once(input logic valid, input logic [31:0] uid);
    card_strobe = 1'b1;
    card_valid  = valid;
    card_uid    = uid;
    tick();
    card_strobe = 1'b0;
    card_valid  = 1'b0;
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int k = 0; k < tbl[i].idle; k++) tick();
      card_strobe = tbl[i].strobe;
      card_valid  = tbl[i].valid;
      card_uid    = tbl[i].uid;
      force_lock  = tbl[i].force_l;
      tick();
      card_strobe = 1'b0;
      card_valid  = 1'b0;
      force_lock  = 1'b0;
      chk_all($sformatf("vec%0d", i), tbl[i].fw, tbl[i].lk, tbl[i].gp, tbl[i].dp,
              tbl[i].suid, tbl[i].fail);
    end
  endtask

  initial begin
    //        idle stb val uid           frc  fw  lk  gp  dp  suid          fail
    tbl[0]  = '{0, 1, 0, 32'h0000_0001, 0,   0,  0,  0,  1,  32'h3322_1100, 4'd1};
    tbl[1]  = '{0, 1, 0, 32'h0000_0002, 0,   0,  0,  0,  1,  32'h3322_1100, 4'd2};
    tbl[2]  = '{0, 1, 0, 32'h0000_0003, 0,   0,  1,  0,  1,  32'h3322_1100, 4'd0};
    tbl[3]  = '{0, 1, 1, 32'h0000_CAFE, 0,   1,  0,  1,  0,  32'h0000_CAFE, 4'd0};
    tbl[4]  = '{25, 0, 0, 32'h0,        0,   0,  0,  0,  0,  32'h0000_CAFE, 4'd0};
    tbl[5]  = '{0, 1, 0, 32'h0000_0011, 0,   0,  0,  0,  1,  32'h0000_CAFE, 4'd1};
    tbl[6]  = '{0, 1, 0, 32'h0000_0012, 0,   0,  0,  0,  1,  32'h0000_CAFE, 4'd2};
    tbl[7]  = '{0, 1, 1, 32'h1234_5678, 0,   1,  0,  1,  0,  32'h1234_5678, 4'd0};
    tbl[8]  = '{0, 1, 0, 32'h0000_0013, 0,   1,  0,  0,  1,  32'h1234_5678, 4'd0};
    tbl[9]  = '{25, 1, 0, 32'h0000_0014, 0,  0,  0,  0,  1,  32'h1234_5678, 4'd1};
    tbl[10] = '{0, 1, 0, 32'h0000_0015, 0,   0,  0,  0,  1,  32'h1234_5678, 4'd2};
    tbl[11] = '{0, 1, 0, 32'h0000_0016, 1,   0,  0,  0,  0,  32'h1234_5678, 4'd2};
    tbl[12] = '{0, 1, 1, 32'h0000_0017, 1,   0,  0,  0,  0,  32'h1234_5678, 4'd2};
    tbl[13] = '{0, 1, 1, 32'hAABB_CCDD, 0,   1,  0,  1,  0,  32'hAABB_CCDD, 4'd0};

    rst_n = 1'b0;
    card_strobe = 1'b0;
    card_valid = 1'b0;
    card_uid = 32'd0;
    force_lock = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("reset", 0, 0, 0, 0, 32'd0, 4'd0);

    // Single grant: fw_enable high for exactly 20 cycles.
    card_strobe = 1'b1; card_valid = 1'b1; card_uid = 32'hB364_DE05;
    for (int k = 1; k <= 21; k++) begin
      tick();
      card_strobe = 1'b0; card_valid = 1'b0;
      chk($sformatf("single fw k=%0d", k), {31'd0, fw_enable}, {31'd0, (k <= 20)});
      chk($sformatf("single grant k=%0d", k), {31'd0, grant_pulse}, {31'd0, (k == 1)});
      chk($sformatf("single uid k=%0d", k), session_uid, 32'hB364_DE05);
    end

    // Extension at T+10 keeps fw_enable continuous through T+30.
    for (int k = 1; k <= 31; k++) begin
      if (k == 1) begin
        card_strobe = 1'b1; card_valid = 1'b1; card_uid = 32'hB364_DE05;
      end else if (k == 11) begin
        card_strobe = 1'b1; card_valid = 1'b1; card_uid = 32'h3322_1100;
      end
      tick();
      card_strobe = 1'b0; card_valid = 1'b0;
      chk($sformatf("extend fw k=%0d", k), {31'd0, fw_enable}, {31'd0, (k <= 30)});
      chk($sformatf("extend grant k=%0d", k), {31'd0, grant_pulse}, {31'd0, (k == 1 || k == 11)});
      chk($sformatf("extend uid k=%0d", k), session_uid,
          (k >= 11) ? 32'h3322_1100 : 32'hB364_DE05);
    end

    apply_range(0, 2);

    // Lockout lasts 30 cycles; a valid card inside it is ignored.
    for (int k = 2; k <= 31; k++) begin
      if (k == 5) begin
        card_strobe = 1'b1; card_valid = 1'b1; card_uid = 32'h0000_0099;
      end
      tick();
      card_strobe = 1'b0; card_valid = 1'b0;
      chk_all($sformatf("lockout k=%0d", k), 0, (k <= 30), 0, 0, 32'h3322_1100, 4'd0);
    end

    apply_range(3, 13);

    // force_lock revokes the session and masks strobes while high.
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk($sformatf("force pre fw k=%0d", k), {31'd0, fw_enable}, 32'd1);
    end
    force_lock = 1'b1;
    tick();
    chk_all("force revoke", 0, 0, 0, 0, 32'hAABB_CCDD, 4'd0);
    strobe_once(1'b1, 32'h5555_5555);
    chk_all("force masked", 0, 0, 0, 0, 32'hAABB_CCDD, 4'd0);
    force_lock = 1'b0;
    strobe_once(1'b1, 32'h5555_5555);
    chk_all("force regrant", 1, 0, 1, 0, 32'h5555_5555, 4'd0);

    // Asynchronous reset mid-session.
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_all("rst session", 0, 0, 0, 0, 32'd0, 4'd0);
    tick();
    rst_n = 1'b1;
    strobe_once(1'b1, 32'h0BAD_BEEF);
    chk_all("post rst grant", 1, 0, 1, 0, 32'h0BAD_BEEF, 4'd0);

    // Asynchronous reset mid-lockout.
    force_lock = 1'b1;
    tick();
    force_lock = 1'b0;
    strobe_once(1'b0, 32'h1);
    strobe_once(1'b0, 32'h2);
    strobe_once(1'b0, 32'h3);
    tick();
    tick();
    chk("lockout before rst", {31'd0, lockout}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all("rst lockout", 0, 0, 0, 0, 32'd0, 4'd0);
    tick();
    rst_n = 1'b1;
    strobe_once(1'b1, 32'h7777_0001);
    chk_all("post lockout rst grant", 1, 0, 1, 0, 32'h7777_0001, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rfid_access_gate.md
Name: rfid_access_gate

Overview:
- Sits directly downstream of the CR95HF RFID reader stage. Consumes each card-check result (valid flag plus 32-bit UID) and opens the firewall data path for a timed session.
- Counts consecutive rejected cards and enforces a timed lockout.
- Provides status strobes and counters for LEDs and the host.

Parameters:
SESSION_CYCLES, 32'd50_000_000, clocks fw_enable stays high per grant (>=2)
LOCKOUT_CYCLES, 32'd100_000_000, clocks lockout stays high after MAX_FAILS (>=2)
MAX_FAILS, 3, consecutive denied cards that trigger lockout (1..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
card_strobe  input  1  one-cycle pulse from reader stage: new result on card_valid/card_uid this cycle
card_valid  input  1  reader verdict, sampled only when card_strobe=1
card_uid  input  32  UID of the presented card, sampled only when card_strobe=1
force_lock  input  1  level, host/admin override: revokes session, masks strobes
fw_enable  output  1  registered; 1 = firewall pass-through permitted
lockout  output  1  registered; 1 = lockout period active
grant_pulse  output  1  one-cycle pulse on each accepted card
deny_pulse  output  1  one-cycle pulse on each rejected card
session_uid  output  32  UID of the card owning the current or last session
fail_count  output  4  consecutive denied cards since last grant or lockout entry

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=LOCKED, fw_enable=0, lockout=0, grant_pulse=0, deny_pulse=0, session_uid=0, fail_count=0, timer=0.
- States: LOCKED, GRANTED, LOCKOUT. All outputs are registered. Response appears the cycle after the strobe.
- Strobe event: card_strobe=1 and force_lock=0 and state!=LOCKOUT. Strobes outside an event are ignored completely: no pulses, no counter change.
- LOCKED, valid event:
  - Next state GRANTED; fw_enable=1; grant_pulse=1.
  - session_uid<=card_uid; fail_count<=0; timer<=SESSION_CYCLES-1.
- LOCKED, invalid event:
  - deny_pulse=1.
  - If fail_count+1==MAX_FAILS: next state LOCKOUT, lockout=1, fail_count<=0, timer<=LOCKOUT_CYCLES-1.
  - Otherwise fail_count<=fail_count+1.
- GRANTED:
  - Timer decrements each cycle.
  - Valid event (same or different UID): reload timer to SESSION_CYCLES-1, session_uid<=card_uid, grant_pulse=1. Session extends with no fw_enable gap.
  - Invalid event: deny_pulse=1; fail_count, timer and fw_enable unchanged.
  - Timer==0 with no valid event that cycle: next state LOCKED, fw_enable=0. fw_enable is therefore high exactly SESSION_CYCLES cycles after a single grant.
  - A valid event in the same cycle as timer==0 wins (extend).
- LOCKOUT:
  - Timer decrements; all strobes ignored.
  - At timer==0: next state LOCKED, lockout=0. lockout is high exactly LOCKOUT_CYCLES cycles.
- force_lock=1:
  - GRANTED goes to LOCKED next cycle: fw_enable=0, timer cleared. session_uid and fail_count are held.
  - Does not shorten or extend LOCKOUT; the timer keeps running.
  - Strobes are masked while high.
- Pulse outputs are high for one cycle only. grant_pulse and deny_pulse are never high together.
- fw_enable and lockout are never high together.
- fail_count saturates: it cannot exceed MAX_FAILS-1 outside transition cycles.
- Reset mid-session or mid-lockout: immediate return to reset values. No session persists across reset.
- Timer is 32-bit unsigned with no wrap: it is loaded only at entry/extend and stops at 0.

Test Plan:
- Bench params SESSION_CYCLES=20, LOCKOUT_CYCLES=30, MAX_FAILS=3.
- Reset release, then valid strobe with uid=32'hB364DE05 at cycle T -> grant_pulse at T+1; fw_enable high T+1..T+20; session_uid=B364DE05; low at T+21.
- Valid strobe at T, then a second valid strobe with uid=32'h33221100 at T+10 -> fw_enable continuous through T+30; session_uid=33221100 from T+11; two grant_pulses.
- Three invalid strobes in LOCKED -> fail_count 1 then 2; third deny_pulse with lockout=1 for exactly 30 cycles, fail_count=0. A valid strobe during lockout -> no pulse, fw_enable stays 0. Valid strobe after lockout -> grant.
- Two invalid strobes, then a valid one -> fail_count returns to 0. Two more invalid strobes -> no lockout (fail_count=2).
- Granted session: assert force_lock at T+5 -> fw_enable 0 at T+6. Valid strobe while force_lock=1 -> ignored. Deassert, then valid strobe -> new grant.
- Assert rst_n=0 mid-session and mid-lockout -> all outputs 0 asynchronously; after release, first valid strobe grants normally.
